// File: rtl/issue_ibuffer_pkg.sv
// Shared definitions for the issue-slice instruction buffer: slice sizing
// constants and the decoded-instruction payload layout it carries.
package issue_ibuffer_pkg;

    localparam int PER_ISSUE_WARPS = 4;
    localparam int IBUF_SIZE       = 4;
    localparam int PERF_CTR_BITS   = 44;

    typedef struct packed {
        logic [43:0] uuid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [2:0]  ex_type;
        logic [3:0]  op_type;
        logic [15:0] op_args;
        logic        wb;
        logic [3:0]  used_rs;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rs3;
    } ibuf_data_t;

    localparam int IBUF_DATAW = $bits(ibuf_data_t);

    // Warp-id width, kept at one bit for a single-warp slice.
    function automatic int wid_bits(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

endpackage

// File: rtl/issue_ibuffer_fifo.sv
// Single-warp ring buffer: DEPTH entries of DATAW bits with occupancy count.
// Head data is read straight from storage; there is no write-to-read bypass.
module issue_ibuffer_fifo #(
    parameter int DEPTH = 4,
    parameter int DATAW = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] push_data,
    output logic [DATAW-1:0] head_data,
    output logic             full,
    output logic             empty
);
    import issue_ibuffer_pkg::*;

    localparam int PTRW = $clog2(DEPTH);

    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW:0]    count_q, count_d;
    logic [DATAW-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTRW+1)'(DEPTH));
    // Guard here as well so the ring can never over- or underflow.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTRW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTRW+1)'(1);
            2'b01:   count_d = count_q - (PTRW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/issue_ibuffer.sv
// Per-issue-slice instruction buffer: demuxes one decoded instruction per cycle
// into per-warp FIFOs and presents every warp head to the scoreboard.
module issue_ibuffer #(
    parameter int NUM_WARPS     = issue_ibuffer_pkg::PER_ISSUE_WARPS,
    parameter int DEPTH         = issue_ibuffer_pkg::IBUF_SIZE,
    parameter int DATAW         = 128,
    parameter int PERF_CTR_BITS = issue_ibuffer_pkg::PERF_CTR_BITS,
    localparam int WIDW         = issue_ibuffer_pkg::wid_bits(NUM_WARPS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDW-1:0]            in_wid,
    input  logic [DATAW-1:0]           in_data,
    output logic                       in_ready,
    output logic [NUM_WARPS-1:0]       out_valid,
    output logic [NUM_WARPS*DATAW-1:0] out_data,
    input  logic [NUM_WARPS-1:0]       out_ready,
    output logic [NUM_WARPS-1:0]       ibuf_pop,
    output logic [NUM_WARPS-1:0]       full,
    output logic [PERF_CTR_BITS-1:0]   ibf_stalls
);
    import issue_ibuffer_pkg::*;

    // Handshake: a transfer happens in any cycle where valid && ready are both
    // high; valid never depends on ready, and ready depends only on registered
    // state plus in_wid, so a full warp refuses input even while it pops.
    logic [NUM_WARPS-1:0]     push, pop, fifo_full, fifo_empty;
    logic [NUM_WARPS-1:0]     ibuf_pop_q, ibuf_pop_d;
    logic [PERF_CTR_BITS-1:0] stalls_q, stalls_d;
    logic                     in_ready_c;

    // An out-of-range wid matches no warp, so it is neither stored nor stalled.
    always_comb begin
        in_ready_c = 1'b1;
        push       = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (32'(in_wid) == w) begin
                in_ready_c = !fifo_full[w];
                push[w]    = in_valid && !fifo_full[w];
            end
        end
    end

    assign pop        = ~fifo_empty & out_ready;
    assign ibuf_pop_d = pop;

    always_comb begin
        stalls_d = stalls_q;
        if (in_valid && !in_ready_c && (stalls_q != '1))
            stalls_d = stalls_q + PERF_CTR_BITS'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ibuf_pop_q <= '0;
            stalls_q   <= '0;
        end else begin
            ibuf_pop_q <= ibuf_pop_d;
            stalls_q   <= stalls_d;
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        issue_ibuffer_fifo #(
            .DEPTH (DEPTH),
            .DATAW (DATAW)
        ) u_fifo (
            .clk       (clk),
            .rst       (reset),
            .push      (push[w]),
            .pop       (pop[w]),
            .push_data (in_data),
            .head_data (out_data[w*DATAW +: DATAW]),
            .full      (fifo_full[w]),
            .empty     (fifo_empty[w])
        );
    end

    assign in_ready   = in_ready_c;
    assign out_valid  = ~fifo_empty;
    assign full       = fifo_full;
    assign ibuf_pop   = ibuf_pop_q;
    assign ibf_stalls = stalls_q;

    illegal_wid_a: assert property (@(posedge clk) disable iff (reset)
        in_valid |-> (32'(in_wid) < NUM_WARPS));

endmodule
